gf_mult_serial: RTL and testbench

Bit-serial GF(2^M) multiply-add unit: computes `out_data = a·b + c` over GF(2^M) for a parametrised width and irreducible polynomial. It uses one shift-and-reduce iteration per clock with valid/ready handshakes on both sides. It is the sequential, parametrised successor to the fixed GF(2^3) combinational multiplier, and sits between operand sources and consumers in the finite-field datapath (RS/BCH syndrome, ECC and arithmetic benchmarks).

---
 rtl/gf_mult_serial.sv | 144 ++++++++++++++
 tb/tb_gf_mult_serial.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf_mult_serial.sv
// gf_mult_serial: bit-serial GF(2^M) multiply-add, out_data = a*b + c mod POLY.
// One MSB-first shift-and-reduce step per clock; valid/ready on both sides.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. The producer holds valid and its data stable until that transfer. The
// consumer may change ready at any time. in_ready is combinational from the
// state and out_ready, so a finished result can be consumed and new operands
// accepted on the same edge. out_valid and out_data are registered.
module gf_mult_serial #(
    parameter int unsigned M    = 3,
    parameter logic [M:0]  POLY = 4'b1011
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] in_a,
    input  logic [M-1:0] in_b,
    input  logic [M-1:0] in_c,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] out_data
);

    // Counter indexes the multiplier bits M-1 down to 0.
    localparam int unsigned CW = (M > 1) ? $clog2(M) : 1;

    // Reject unusable field parameters at elaboration.
    generate
        if (M < 2 || M > 32) begin : g_bad_width
            $error("gf_mult_serial: M must be in 2..32");
        end
        if (POLY[M] != 1'b1) begin : g_bad_poly
            $error("gf_mult_serial: POLY bit M must be set");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [M-1:0]    a_q, a_d;
    logic [M-1:0]    b_q, b_d;
    logic [M-1:0]    c_q, c_d;
    logic [M-1:0]    r_q, r_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [M-1:0]    out_data_q, out_data_d;

    logic            accept;
    logic [M-1:0]    r_step;

    // Ready when idle, or when the held result leaves on this same edge.
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // One Horner step: multiply the partial result by x, reduce, add a if b[cnt].
    always_comb begin
        r_step = {r_q[M-2:0], 1'b0}
               ^ (r_q[M-1]    ? POLY[M-1:0] : '0)
               ^ (b_q[cnt_q]  ? a_q         : '0);
    end

    // Next-state logic: load on accept, iterate in BUSY, hold or release in DONE.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        r_d         = r_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    c_d     = in_c;
                    r_d     = '0;
                    cnt_d   = CW'(M - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                r_d   = r_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    out_data_d  = r_step ^ c_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                    if (accept) begin
                        a_d     = in_a;
                        b_d     = in_b;
                        c_d     = in_c;
                        r_d     = '0;
                        cnt_d   = CW'(M - 1);
                        state_d = BUSY;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight work at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_gf_mult_serial.sv
// Bench for gf_mult_serial: one M=3 instance and one M=8 (AES field) instance.
module tb_gf_mult_serial;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       v3, ir3, ov3, ordy3;
  logic [2:0] a3, b3, c3, od3;
  logic       v8, ir8, ov8, ordy8;
  logic [7:0] a8, b8, c8, od8;

  gf_mult_serial #(.M(3), .POLY(4'b1011)) u_dut3 (
    .clk(clk), .rst(rst),
    .in_valid(v3), .in_ready(ir3), .in_a(a3), .in_b(b3), .in_c(c3),
    .out_valid(ov3), .out_ready(ordy3), .out_data(od3)
  );

  gf_mult_serial #(.M(8), .POLY(9'h11B)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(v8), .in_ready(ir8), .in_a(a8), .in_b(b8), .in_c(c8),
    .out_valid(ov8), .out_ready(ordy8), .out_data(od8)
  );

  // Selected instance view (sel = 3 or 8).
  int         sel;
  logic       ov_s, ir_s;
  logic [7:0] od_s;
  always_comb begin
    if (sel == 3) begin
      ov_s = ov3; ir_s = ir3; od_s = {5'b0, od3};
    end else begin
      ov_s = ov8; ir_s = ir8; od_s = od8;
    end
  end

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: full carry-less product, then polynomial long division.
  function automatic logic [7:0] gf_ref(input int m, input logic [7:0] a, b, c);
    logic [15:0] p;
    logic [15:0] poly;
    p    = '0;
    poly = (m == 3) ? 16'h000B : 16'h011B;
    for (int i = 0; i < m; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 2 * m - 2; i >= m; i--)
      if (p[i]) p = p ^ (poly << (i - m));
    return p[7:0] ^ c;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit v, input logic [7:0] a, b, c, input bit ordy);
    if (sel == 3) begin
      v3 = v; a3 = a[2:0]; b3 = b[2:0]; c3 = c[2:0]; ordy3 = ordy;
    end else begin
      v8 = v; a8 = a; b8 = b; c8 = c; ordy8 = ordy;
    end
    #1;
  endtask

  // Count edges until out_valid, bounded.
  task automatic wait_valid(input string name, inout int lat);
    while (!ov_s && lat < 64) begin
      tick();
      lat++;
    end
    check({name, "_valid_seen"}, ov_s, 1'b1);
  endtask

  // Single operation with out_ready high; returns result and accept-to-valid latency.
  task automatic do_op(input string name, input logic [7:0] a, b, c,
                       output logic [7:0] res, output int lat);
    int g;
    g = 0;
    drive(1'b1, a, b, c, 1'b1);
    while (!ir_s && g < 50) begin
      tick();
      g++;
    end
    tick();                              // accept edge
    drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    check({name, "_busy_in_ready"}, ir_s, 1'b0);
    lat = 0;
    wait_valid(name, lat);
    res = od_s;
    tick();                              // consume edge
    check({name, "_valid_cleared"}, ov_s, 1'b0);
  endtask

  // Streaming random run with gaps on both sides against an expected queue.
  task automatic run_random(input int m, input int nops);
    logic [7:0] exp_q[$];
    logic [7:0] pa, pb, pc;
    int issued, n_acc, n_res, cyc;
    bit v, ordy, acc, cons;
    sel = m;
    issued = 0; n_acc = 0; n_res = 0; cyc = 0;
    if (m == 3) begin
      pa = 8'd0; pb = 8'd0; pc = 8'd0;
    end else begin
      pa = 8'($urandom); pb = 8'($urandom); pc = 8'($urandom);
    end
    while (n_res < nops && cyc < 30000) begin
      v    = (issued < nops) && ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      drive(v, pa, pb, pc, ordy);
      acc  = v && ir_s;
      cons = ov_s && ordy;
      if (cons) begin
        if (exp_q.size() == 0) check($sformatf("rand_m%0d_unexpected", m), 1, 0);
        else check($sformatf("rand_m%0d_data_%0d", m, n_res), od_s, exp_q.pop_front());
        n_res++;
      end
      if (acc) begin
        exp_q.push_back(gf_ref(m, pa, pb, pc));
        n_acc++;
        issued++;
        if (m == 3) begin
          pa = 8'((issued >> 6) & 7); pb = 8'((issued >> 3) & 7); pc = 8'(issued & 7);
        end else begin
          pa = 8'($urandom); pb = 8'($urandom); pc = 8'($urandom);
        end
      end
      tick();
      cyc++;
    end
    drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    check($sformatf("rand_m%0d_results", m), n_res, nops);
    check($sformatf("rand_m%0d_acc_vs_res", m), n_acc, n_res);
    check($sformatf("rand_m%0d_queue_empty", m), exp_q.size(), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         m;
    logic [7:0] a, b, c, exp;
  } vec_t;

  vec_t vecs[9];

  // ---------------- main test ----------------
  initial begin
    logic [7:0] res, held;
    int lat, gap;

    sel = 3;
    {v3, ordy3, a3, b3, c3} = '0;
    {v8, ordy8, a8, b8, c8} = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("reset_in_ready_m3", ir3, 1'b1);
    check("reset_out_valid_m3", ov3, 1'b0);
    check("reset_out_data_m3", od3, 3'd0);
    check("reset_in_ready_m8", ir8, 1'b1);
    check("reset_out_valid_m8", ov8, 1'b0);
    check("reset_out_data_m8", od8, 8'd0);
    rst = 1'b0;
    tick();

    vecs[0] = '{3, 8'd3,  8'd5,  8'd0,  8'd4};
    vecs[1] = '{3, 8'd7,  8'd7,  8'd6,  8'd5};
    vecs[2] = '{3, 8'd0,  8'd6,  8'd2,  8'd2};
    vecs[3] = '{3, 8'd2,  8'd4,  8'd0,  8'd3};
    vecs[4] = '{3, 8'd1,  8'd1,  8'd1,  8'd0};
    vecs[5] = '{8, 8'h57, 8'h83, 8'h00, 8'hC1};
    vecs[6] = '{8, 8'h57, 8'h13, 8'h00, 8'hFE};
    vecs[7] = '{8, 8'h02, 8'h80, 8'h00, 8'h1B};
    vecs[8] = '{8, 8'hFF, 8'h00, 8'h5A, 8'h5A};

    for (int i = 0; i < 9; i++) begin
      sel = vecs[i].m;
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, res, lat);
      check($sformatf("vec%0d_data", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].m);
    end

    // Back-to-back with continuous in_valid: results M+1 = 9 cycles apart.
    sel = 8;
    drive(1'b1, 8'h57, 8'h83, 8'h00, 1'b1);
    tick();
    drive(1'b1, 8'h57, 8'h13, 8'h00, 1'b1);
    lat = 0;
    wait_valid("b2b_first", lat);
    check("b2b_first_data", od_s, 8'hC1);
    check("b2b_in_ready_done", ir_s, 1'b1);
    tick();                              // consume + accept
    drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    check("b2b_no_stale_valid", ov_s, 1'b0);
    gap = 1;
    wait_valid("b2b_second", gap);
    check("b2b_gap", gap, 9);
    check("b2b_second_data", od_s, 8'hFE);
    tick();

    // Back-pressure: hold in DONE for 10 cycles, then consume + accept together.
    drive(1'b1, 8'h57, 8'h83, 8'h00, 1'b0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    lat = 0;
    wait_valid("bp", lat);
    held = od_s;
    check("bp_data", held, 8'hC1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("bp_hold_data_%0d", i), od_s, 8'hC1);
      check($sformatf("bp_hold_valid_%0d", i), ov_s, 1'b1);
      check($sformatf("bp_hold_in_ready_%0d", i), ir_s, 1'b0);
    end
    drive(1'b1, 8'h02, 8'h80, 8'h01, 1'b1);
    check("bp_release_in_ready", ir_s, 1'b1);
    tick();
    drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    check("bp_release_valid_low", ov_s, 1'b0);
    lat = 0;
    wait_valid("bp_next", lat);
    check("bp_next_latency", lat, 8);
    check("bp_next_data", od_s, 8'h1A);
    tick();

    // Asynchronous reset during BUSY (second step of an M=8 operation).
    drive(1'b1, 8'h57, 8'h13, 8'h00, 1'b1);
    tick();
    drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    tick();
    rst = 1'b1;
    #1;
    check("arst_out_valid", ov8, 1'b0);
    check("arst_in_ready", ir8, 1'b1);
    check("arst_out_data", od8, 8'h00);
    #1;
    rst = 1'b0;
    tick();
    do_op("post_rst", 8'hCA, 8'h53, 8'h00, res, lat);
    check("post_rst_data", res, 8'h01);
    check("post_rst_latency", lat, 8);

    // Randomised: M=3 exhaustive, M=8 random, total 1000 operations.
    run_random(3, 512);
    run_random(8, 488);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog: never hang.
  initial begin
    #5ms;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
